// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the Galois LFSR stream source.
//   - Maximal-length tap masks for common register lengths.
//   - lfsr_shift(): one Galois step. It works on 32-bit zero-extended values
//     so that any LEN up to 32 can use it. The upper bits stay zero as long as
//     the taps fit in LEN bits.
package lfsr_pkg;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [23:0] TAPS_24 = 24'hE10000;
    localparam logic [31:0] TAPS_32 = 32'hA3000000;

    // Shift right and fold the outgoing LSB back in through the tap mask.
    function automatic logic [31:0] lfsr_shift(input logic [31:0] state,
                                               input logic [31:0] taps);
        return {1'b0, state[31:1]} ^ (state[0] ? taps : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr_stepper.sv
// lfsr_stepper: purely combinational multi-step Galois LFSR advance.
// Ports:
//   i_state  LEN-bit current state
//   o_next   state after STEP single shifts
module lfsr_stepper
    import lfsr_pkg::*;
#(
    parameter int unsigned     LEN  = 16,
    parameter logic [LEN-1:0]  TAPS = TAPS_16,
    parameter int unsigned     STEP = 1
) (
    input  logic [LEN-1:0] i_state,
    output logic [LEN-1:0] o_next
);

    logic [LEN-1:0] w_acc;

    // Unrolled at elaboration: STEP chained XOR stages in a single cycle.
    always_comb begin
        w_acc = i_state;
        for (int unsigned k = 0; k < STEP; k++) begin
            w_acc = LEN'(lfsr_shift(32'(w_acc), 32'(TAPS)));
        end
        o_next = w_acc;
    end

endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream: Galois LFSR pseudo-random source with a valid/ready output.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_en           generation enable
//   i_seed_load    pulse: reload state from i_seed (zero seed -> all-ones)
//   i_seed         seed value
//   o_out_valid    o_out_data holds an unconsumed word
//   i_out_ready    consumer accepts the word
//   o_out_data     low OUT_W bits of the state after each advance
//   o_wrap         one-cycle pulse when the state returns to the start state
//   o_period       advances between the last two wraps (0 until the first)
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int unsigned     LEN   = 16,
    parameter logic [LEN-1:0]  TAPS  = TAPS_16,
    parameter int unsigned     STEP  = 1,
    parameter int unsigned     OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_seed_load,
    input  logic [LEN-1:0]   i_seed,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [OUT_W-1:0] o_out_data,
    output logic             o_wrap,
    output logic [LEN-1:0]   o_period
);

    logic [LEN-1:0]   r_sreg;
    logic [LEN-1:0]   r_start;
    logic [LEN-1:0]   r_count;
    logic [LEN-1:0]   r_period;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_wrap;

    logic [LEN-1:0]   w_eff_seed;
    logic [LEN-1:0]   w_next;
    logic             w_advance;
    logic             w_hit_start;

    lfsr_stepper #(
        .LEN  (LEN),
        .TAPS (TAPS),
        .STEP (STEP)
    ) u_stepper (
        .i_state (r_sreg),
        .o_next  (w_next)
    );

    // A zero seed would lock the register at zero, so substitute all-ones.
    assign w_eff_seed  = (i_seed != '0) ? i_seed : '1;
    assign w_advance   = i_en && !i_seed_load && (!r_out_valid || i_out_ready);
    assign w_hit_start = (w_next == r_start);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg      <= w_eff_seed;
            r_start     <= w_eff_seed;
            r_count     <= '0;
            r_period    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
        end else if (i_seed_load) begin
            // Reload wins over advance; any pending word is dropped.
            r_sreg      <= w_eff_seed;
            r_start     <= w_eff_seed;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_advance) begin
                r_sreg      <= w_next;
                r_out_data  <= w_next[OUT_W-1:0];
                r_out_valid <= 1'b1;
                if (w_hit_start) begin
                    r_wrap   <= 1'b1;
                    r_period <= r_count + LEN'(1);
                    r_count  <= '0;
                end else begin
                    r_count  <= r_count + LEN'(1);
                end
            end else if (r_out_valid && i_out_ready) begin
                // Word consumed while disabled: go empty, state holds.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_wrap      = r_wrap;
    assign o_period    = r_period;

endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: self-checking bench for lfsr_stream.
// Two 8-bit instances (STEP=1 and STEP=8) run against a reference model. The
// model tracks the number of advances since the start state and derives the
// expected word by walking the single-step sequence.
module tb_lfsr_stream;
    import lfsr_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rdy;
    logic       sl0, sl1;
    logic [7:0] sd0, sd1;
    logic       v0, v1, w0, w1;
    logic [7:0] d0, d1, p0, p1;

    int checks   = 0;
    int failures = 0;

    lfsr_stream #(.LEN(8), .TAPS(TAPS_8), .STEP(1), .OUT_W(8)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .i_en        (en),
        .i_seed_load (sl0),
        .i_seed      (sd0),
        .o_out_valid (v0),
        .i_out_ready (rdy),
        .o_out_data  (d0),
        .o_wrap      (w0),
        .o_period    (p0)
    );

    lfsr_stream #(.LEN(8), .TAPS(TAPS_8), .STEP(8), .OUT_W(8)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .i_en        (en),
        .i_seed_load (sl1),
        .i_seed      (sd1),
        .o_out_valid (v1),
        .i_out_ready (rdy),
        .o_out_data  (d1),
        .o_wrap      (w1),
        .o_period    (p1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one slot per instance.
    int unsigned m_step[2] = '{1, 8};
    int unsigned m_per[2];
    int unsigned m_idx[2];
    logic [7:0]  m_start[2];
    bit          m_valid[2];
    bit          m_wrap[2];
    bit          m_had[2];
    bit          m_zero[2];

    function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [7:0] state_after(input logic [7:0] s, input int unsigned n);
        logic [7:0] x;
        x = s;
        for (int unsigned k = 0; k < n; k++) x = 8'(lfsr_shift(32'(x), 32'(TAPS_8)));
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i, input bit r, input bit e, input bit rd,
                              input bit sl, input logic [7:0] sd);
        logic [7:0] eff;
        eff = (sd != 8'h00) ? sd : 8'hFF;
        if (r) begin
            m_start[i] = eff; m_idx[i] = 0; m_valid[i] = 0;
            m_wrap[i] = 0; m_had[i] = 0; m_zero[i] = 1;
        end else if (sl) begin
            m_start[i] = eff; m_idx[i] = 0; m_valid[i] = 0; m_wrap[i] = 0;
        end else if (e && (!m_valid[i] || rd)) begin
            m_idx[i]++;
            m_valid[i] = 1;
            m_zero[i] = 0;
            m_wrap[i] = (m_idx[i] % m_per[i]) == 0;
            if (m_wrap[i]) m_had[i] = 1;
        end else begin
            m_wrap[i] = 0;
            if (m_valid[i] && rd) m_valid[i] = 0;
        end
    endtask

    task automatic check_dut(input string tag, input int i, input logic v, input logic [7:0] d,
                             input logic w, input logic [7:0] p);
        logic [7:0] exp_d;
        check({tag, "_valid"}, 32'(v), 32'(m_valid[i]));
        check({tag, "_wrap"}, 32'(w), 32'(m_wrap[i]));
        check({tag, "_period"}, 32'(p), m_had[i] ? m_per[i] : 32'd0);
        if (m_valid[i]) begin
            exp_d = state_after(m_start[i], (m_idx[i] * m_step[i]) % 255);
            check({tag, "_data"}, 32'(d), 32'(exp_d));
        end else if (m_zero[i]) begin
            check({tag, "_data_rst"}, 32'(d), 32'd0);
        end
    endtask

    task automatic tick();
        model_step(0, rst, en, rdy, sl0, sd0);
        model_step(1, rst, en, rdy, sl1, sd1);
        @(posedge clk);
        #1;
        check_dut("s1", 0, v0, d0, w0, p0);
        check_dut("s8", 1, v1, d1, w1, p1);
    endtask

    logic [7:0] saved;

    initial begin
        for (int i = 0; i < 2; i++) m_per[i] = 255 / gcd(m_step[i], 255);

        // Reset with default (zero) seed on dut0 and seed 01 on dut1.
        rst = 1; en = 0; rdy = 0; sl0 = 0; sl1 = 0; sd0 = 8'h00; sd1 = 8'h01;
        tick();
        tick();

        // Continuous streaming over two full periods.
        rst = 0; en = 1; rdy = 1;
        for (int n = 1; n <= 600; n++) begin
            tick();
            if (n == 1) check("first_word", 32'(d0), 32'h0000_00C7);
            if (n == 255) begin
                check("word255_data", 32'(d0), 32'h0000_00FF);
                check("word255_wrap", 32'(w0), 32'd1);
                check("word255_period", 32'(p0), 32'd255);
                check("step8_wrap255", 32'(w1), 32'd1);
            end
            if (n == 510) check("word510_wrap", 32'(w0), 32'd1);
        end

        // Backpressure: data must hold while the consumer stalls.
        saved = d0;
        rdy = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("stall_stable", 32'(d0), 32'(saved));
        end
        rdy = 1;
        tick();

        // Randomised enable, ready and occasional reseeds.
        for (int n = 0; n < 1500; n++) begin
            en  = ($urandom_range(0, 3) != 0);
            rdy = $urandom_range(0, 1) == 1;
            sl0 = ($urandom_range(0, 49) == 0);
            sl1 = ($urandom_range(0, 49) == 0);
            sd0 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            sd1 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            tick();
        end
        sl0 = 0; sl1 = 0;

        // Reseed while a word is pending, with advance conditions present.
        en = 1; rdy = 0;
        tick();
        tick();
        check("pre_reseed_valid", 32'(v0), 32'd1);
        saved = p0;
        sl0 = 1; sd0 = 8'h5A; rdy = 1;
        tick();
        check("reseed_valid", 32'(v0), 32'd0);
        check("reseed_period_kept", 32'(p0), 32'(saved));
        sl0 = 0;
        tick();
        check("reseed_first", 32'(d0), 32'h0000_002D);
        for (int n = 2; n <= 300; n++) begin
            tick();
            if (n == 255) begin
                check("reseed_wrap", 32'(w0), 32'd1);
                check("reseed_wrap_data", 32'(d0), 32'h0000_005A);
            end
        end

        // Reset beats seed_load and advance.
        rst = 1; en = 1; rdy = 1; sl0 = 1; sl1 = 1;
        tick();
        check("rst_valid", 32'(v0), 32'd0);
        check("rst_wrap", 32'(w0), 32'd0);
        check("rst_period", 32'(p0), 32'd0);
        rst = 0; sl0 = 0; sl1 = 0;
        tick();
        check("rst_first", 32'(d0), 32'(state_after(8'h5A, 1)));
        for (int n = 0; n < 20; n++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_stream.md
Name: lfsr_stream

Overview:
Parametrised Galois LFSR pseudo-random source with a valid/ready output stream.
- Advances STEP shifts per accepted word and presents the low OUT_W bits.
- Supports run-time reseeding without reset.
- Reports sequence wrap (return to start state) and the measured period.
- Feeds test-pattern generators, dithering and noise blocks in the maths library.

Parameters:
LEN, 16, shift register length in bits (2..32)
TAPS, 16'hB400, Galois XOR tap mask (LEN bits); maximal-length constants come from lfsr_pkg
STEP, 1, shifts applied per output word (1..LEN)
OUT_W, 8, output word width (1..LEN); low OUT_W bits of the state

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  generation enable
seed_load  in  1  pulse: reload state from seed
seed  in  LEN  seed value; zero means default all-ones
out_valid  out  1  out_data holds an unconsumed word
out_ready  in  1  consumer accepts word
out_data  out  OUT_W  pseudo-random word
wrap  out  1  one-cycle pulse: state just returned to start state
period  out  LEN  advances between the last two wraps (0 until first wrap)

Behaviour:
- Single shift: s' = {0, s[LEN-1:1]} ^ (s[0] ? TAPS : 0). next = single shift applied STEP times, combinational within one cycle.
- Seed resolution: eff_seed = (seed != 0) ? seed : all-ones.
- Reset (rst=1; beats every other input):
  - sreg = eff_seed, start = eff_seed
  - out_valid = 0, out_data = 0, wrap = 0, period = 0, count = 0
- advance = en && !seed_load && (!out_valid || out_ready).
- On advance:
  - sreg <= next
  - out_data <= next[OUT_W-1:0]
  - out_valid <= 1
  - Latency: word visible the cycle after advance.
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - If out_valid && out_ready && !en: out_valid <= 0, sreg holds.
  - While out_valid && !out_ready: out_data and sreg stable; no advance regardless of en.
  - Back-to-back transfer every cycle with en=1 and out_ready=1.
- seed_load (rst=0):
  - sreg = eff_seed, start = eff_seed
  - out_valid = 0, count = 0, wrap = 0; period retained
  - Takes priority over advance in the same cycle; a pending word is discarded.
- Wrap and period (count is LEN bits):
  - On advance where next == start: wrap = 1 for one cycle, aligned with the new word's out_valid; period <= count+1; count <= 0.
  - On any other advance: count <= count+1.
  - wrap = 0 in all other cycles.
- Period for maximal TAPS = (2^LEN-1)/gcd(STEP, 2^LEN-1); always fits in LEN bits.
- All-zero state is unreachable: zero seed is substituted and the Galois step preserves non-zero states.
- No X on outputs after the first reset cycle.

Decomposition:
- lfsr_pkg:
  - maximal tap constants TAPS_8=8'hB8, TAPS_16=16'hB400, TAPS_24=24'hE10000, TAPS_32=32'hA3000000
  - function lfsr_shift(state, taps) for a single Galois step, shared with the bench model
- One combinational sub-module lfsr_stepper (LEN, TAPS, STEP): state in, next out, loop of lfsr_shift.
- Top level holds the handshake, seed, wrap and period logic.

Test Plan:
- Default seed: LEN=8, TAPS=8'hB8, STEP=1, OUT_W=8, seed=0, reset, then en=1, out_ready=1 -> first out_data=8'hC7 one cycle after en; subsequent words match the lfsr_pkg model.
- Full period: same configuration, run continuously -> wrap pulses on the 255th word (value 8'hFF), period=255; wrap recurs every 255 words.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1, en=1 -> out_data stable, no advance; after out_ready=1 the next word equals the model's next value (no skipped states).
- Multi-step: LEN=8, STEP=8, seed=8'h01 -> each word equals every 8th state of the STEP=1 model; period=255; wrap after word 255.
- Reseed mid-stream: seed_load with seed=8'h5A while out_valid=1 -> out_valid=0 next cycle, count cleared, period unchanged; next word = step(8'h5A); seed_load together with advance conditions -> reload wins.
- Reset mid-operation: rst=1 with en=1, out_ready=1, seed_load=1 -> next cycle out_valid=0, wrap=0, period=0, sreg = eff_seed.
